seven_segment_mux: RTL and testbench
====================================

Name: seven_segment_mux

Overview:
- Parametrised multiplexed driver for common-anode hex displays, replacing the fixed 8-digit driver.
- Scans NUM_DIGITS digits from one clock-enable prescaler, with no derived clocks.
- Adds full 0-F decode, per-digit decimal point and enable, inter-digit ghost blanking, and a frame-coherent data snapshot.
- Sits between the miner status/debug registers and the board's cathode and anode pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- CLK_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz slot rate); must be >= 2.
- BLANK_CYCLES, 1000, clocks at the start of each slot with all anodes off; must be < CLK_DIV; 0 disables blanking.

Ports:
- clock, input, 1, system clock; all logic is on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- data, input, 4*NUM_DIGITS, nibble i = data[4i+3:4i] is shown on digit i.
- dp, input, NUM_DIGITS, 1 lights the decimal point of digit i.
- digit_en, input, NUM_DIGITS, 0 keeps digit i dark during its slot.
- ca, output, 8, active-low cathodes; ca[6:0] = segments g..a, ca[7] = dp.
- an, output, NUM_DIGITS, active-low anodes; at most one bit is low.
- frame_start, output, 1, one-clock pulse when digit 0's slot begins.

Behaviour:
- Reset (asynchronous, while reset_n=0): ca=8'hFF, an=all ones, frame_start=0. Prescaler, digit index, state and snapshot registers all clear to 0. State = BLANK.
- Prescaler: counts 0..CLK_DIV-1 and wraps. The cycle where it equals CLK_DIV-1 is a "tick". Width is $clog2(CLK_DIV).
- Digit index: advances on each tick and wraps NUM_DIGITS-1 -> 0.
- Snapshot: on a tick where the index wraps to 0, data, dp and digit_en are captured. The whole frame shows the captured values; input changes mid-frame have no visible effect until the next frame.
- frame_start: asserted for exactly the clock following that wrapping tick.
- State machine, two states:
  - BLANK: an = all ones, ca = 8'hFF. Leaves for SHOW once BLANK_CYCLES clocks have elapsed in the slot.
  - SHOW: an[index] = ~snap_en[index], all other an bits = 1; ca = decode(snap nibble) with ca[7] = ~snap_dp[index].
  - Every tick enters BLANK. If BLANK_CYCLES = 0, a tick goes directly to SHOW of the new index.
- Outputs are registered. an/ca reflect the new state one clock after the state transition.
- Decode table (hex, active-low, bit7 set), digits 0-F in order: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Out-of-range nibbles do not exist; all 16 codes are defined.
- First frame after reset shows the reset snapshot (all zeros, all digits disabled), i.e. dark until the first wrap.
- Reset asserted mid-slot: outputs go dark immediately (asynchronously). On release, scanning restarts at digit 0 in BLANK.

Optional Feature:
- Macro: SEVEN_SEGMENT_LZB_EN (leading-zero blanking).
- Defined: at snapshot, every digit above the most significant nonzero snapshot nibble is forced disabled. Digit 0 is never suppressed, so 0 shows as a single "0". This is ANDed with snap_en.
- Undefined: all enabled digits display, including leading zeros.

Decomposition:
- Package seven_segment_pkg holds the 16-entry segment constant table, the all-off constant 8'hFF, and the active-low polarity constants.
- Sub-module hex_to_segments is the combinational nibble-to-segment decoder using the package table.
- Prescaler, index counter, FSM and snapshot stay in seven_segment_mux.

Test Plan:
- Common bench setup: NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
- Reset check: hold reset_n=0 for 5 clocks -> ca=FF, an=F, frame_start=0. Toggle reset_n low mid-SHOW -> an=F in the same cycle, before the next edge.
- Basic scan: data=16'hA3F0, dp=4'b0100, digit_en=F -> per slot, 2 clocks of an=F, then an=E/ca=C0, an=D/ca=8E, an=B/ca=30 (dp lit, B0 & 7F), an=7/ca=88. frame_start pulses every 32 clocks.
- Snapshot coherence: change data to 16'h1111 during digit 2's slot -> digits 2 and 3 keep the old values. The new value appears only after the next frame_start.
- Disable and blanking: digit_en=4'b1010 -> an never drives digits 0 or 2 low. No clock ever has two anodes low. Never two digits lit without an intervening BLANK_CYCLES gap.
- LZB build: data=16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. data=16'h0000 -> only digit 0 shows 0. Without the macro, all four digits are lit.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed common-anode hex display driver:
// segment table, polarities and the scan FSM state type.
package seven_segment_pkg;

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } state_e;

  // Cathodes and anodes are both active-low.
  localparam logic       AnOn   = 1'b0;
  localparam logic       AnOff  = 1'b1;
  localparam logic       DpOn   = 1'b0;
  localparam logic       DpOff  = 1'b1;
  localparam logic [7:0] SegOff = 8'hFF;

  // Index n holds the pattern for hex digit n; bit 7 (dp) is off in every entry.
  localparam logic [15:0][7:0] SegTable = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_lookup(input logic [3:0] nibble);
    return SegTable[nibble];
  endfunction

endpackage

// File: rtl/hex_to_segments.sv
// Combinational nibble-to-cathode decoder for one digit, with decimal point merge.
module hex_to_segments
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp_on,
  output logic [7:0] seg
);

  always_comb begin
    seg    = seg_lookup(nibble);
    seg[7] = dp_on ? DpOn : DpOff;
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Multiplexed common-anode hex display driver with per-frame data snapshot and
// inter-digit ghost blanking. Define SEVEN_SEGMENT_LZB_EN for leading-zero blanking.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7:0]              ca,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned PresW = $clog2(CLK_DIV);
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PresW-1:0] PresLast  = PresW'(CLK_DIV - 1);
  localparam logic [PresW-1:0] BlankLast = PresW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);

  logic [PresW-1:0]        presc_q, presc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] snap_data_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_en_q, snap_en_d;
  logic [7:0]              ca_q, ca_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q;

  logic                    tick, wrap;
  logic [NUM_DIGITS-1:0]   keep;
  logic [3:0]              cur_nibble;
  logic [7:0]              cur_seg;

  assign tick = (presc_q == PresLast);
  assign wrap = tick && (idx_q == IdxLast);

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      presc_d = '0;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      state_d = (BLANK_CYCLES == 0) ? StShow : StBlank;
    end else if (state_q == StBlank && (BLANK_CYCLES == 0 || presc_q == BlankLast)) begin
      state_d = StShow;
    end
  end

`ifdef SEVEN_SEGMENT_LZB_EN
  // Walk from the top digit down; a digit survives once any nibble at or above it is nonzero.
  always_comb begin
    logic seen;
    seen = 1'b0;
    keep = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      seen    = seen | (|data[4*i +: 4]);
      keep[i] = seen || (i == 0);
    end
  end
`else
  assign keep = '1;
`endif

  assign snap_en_d = digit_en & keep;

  assign cur_nibble = 4'(snap_data_q >> {idx_q, 2'b00});

  hex_to_segments u_decode (
    .nibble (cur_nibble),
    .dp_on  (snap_dp_q[idx_q]),
    .seg    (cur_seg)
  );

  // Output image is derived from the current state; it lands one clock after the state.
  always_comb begin
    an_d = '1;
    ca_d = SegOff;
    if (state_q == StShow) begin
      an_d[idx_q] = snap_en_q[idx_q] ? AnOn : AnOff;
      ca_d        = cur_seg;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      state_q       <= StBlank;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      ca_q          <= SegOff;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      ca_q          <= ca_d;
      an_q          <= an_d;
      frame_start_q <= wrap;
      if (wrap) begin
        snap_data_q <= data;
        snap_dp_q   <= dp;
        snap_en_q   <= snap_en_d;
      end
    end
  end

  assign ca          = ca_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed self-checking bench for seven_segment_mux (4 digits, 8-clock slots, 2 blank clocks).
module tb_seven_segment_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned CD = 8;
  localparam int unsigned BC = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   data = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    digit_en = '0;
  logic [7:0]    ca;
  logic [3:0]    an;
  logic          frame_start;

  int errors = 0;
  int checks = 0;

  seven_segment_mux #(
    .NUM_DIGITS   (N),
    .CLK_DIV      (CD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .data        (data),
    .dp          (dp),
    .digit_en    (digit_en),
    .ca          (ca),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advances to the next negedge where frame_start is seen; ok=0 if the bound expires.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    data     = 16'hA3F0;
    dp       = 4'b0100;
    digit_en = 4'hF;
    reset_n  = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (ca !== 8'hFF) begin errors++; $display("FAIL reset_ca got=%h exp=ff", ca); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=f", an); end
    checks++; if (frame_start !== 1'b0) begin
      errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start);
    end
    reset_n = 1'b1;
    // First frame uses the cleared snapshot: dark throughout, first pulse after 32 clocks.
    for (int n = 1; n <= 32; n++) begin
      @(negedge clock);
      checks++; if (an !== 4'hF) begin
        errors++; $display("FAIL first_frame_dark n=%0d got=%h exp=f", n, an);
      end
      checks++; if (frame_start !== (n == 32)) begin
        errors++; $display("FAIL first_frame_start n=%0d got=%b exp=%b", n, frame_start, n == 32);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] ean[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] eca[4] = '{8'hC0, 8'h8E, 8'h30, 8'h88};
    bit ok;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL scan_frame got=timeout exp=pulse"); end
    for (int k = 1; k <= 32; k++) begin
      int s;
      int off;
      @(negedge clock);
      s   = (k - 1) / 8;
      off = (k - 1) % 8;
      if (off < 2) begin
        checks++; if (an !== 4'hF || ca !== 8'hFF) begin
          errors++; $display("FAIL scan_blank k=%0d got an=%h ca=%h exp an=f ca=ff", k, an, ca);
        end
      end else begin
        checks++; if (an !== ean[s] || ca !== eca[s]) begin
          errors++;
          $display("FAIL scan_digit k=%0d got an=%h ca=%h exp an=%h ca=%h", k, an, ca, ean[s], eca[s]);
        end
      end
      checks++; if (frame_start !== (k == 32)) begin
        errors++; $display("FAIL scan_frame_start k=%0d got=%b exp=%b", k, frame_start, k == 32);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    for (int k = 1; k <= 5; k++) @(negedge clock);
    checks++; if (an !== 4'hE) begin errors++; $display("FAIL pre_reset_show got=%h exp=e", an); end
    reset_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF || ca !== 8'hFF) begin
      errors++; $display("FAIL async_reset got an=%h ca=%h exp an=f ca=ff", an, ca);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clock);
      checks++; if (an !== 4'hF) begin
        errors++; $display("FAIL restart_dark n=%0d got=%h exp=f", n, an);
      end
      checks++; if (frame_start !== (n == 32)) begin
        errors++; $display("FAIL restart_frame n=%0d got=%b exp=%b", n, frame_start, n == 32);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] eca2[4] = '{8'hF9, 8'hF9, 8'h79, 8'hF9};
    logic [3:0] ean[4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
    // Frame showing A3F0 is in progress; change the data inside digit 2's slot.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (k == 18) data = 16'h1111;
      if (k == 19) begin
        checks++; if (an !== 4'hB || ca !== 8'h30) begin
          errors++; $display("FAIL snap_digit2 got an=%h ca=%h exp an=b ca=30", an, ca);
        end
      end
      if (k == 27) begin
        checks++; if (an !== 4'h7 || ca !== 8'h88) begin
          errors++; $display("FAIL snap_digit3 got an=%h ca=%h exp an=7 ca=88", an, ca);
        end
      end
    end
    checks++; if (frame_start !== 1'b1) begin
      errors++; $display("FAIL snap_frame got=%b exp=1", frame_start);
    end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (k % 8 == 3) begin
        checks++; if (an !== ean[k/8] || ca !== eca2[k/8]) begin
          errors++;
          $display("FAIL snap_new k=%0d got an=%h ca=%h exp an=%h ca=%h", k, an, ca, ean[k/8], eca2[k/8]);
        end
      end
    end
  endtask

  task automatic test_disable_blanking();
    bit         ok;
    int         dark = 0;
    logic [3:0] prev_lit = 4'hF;
    digit_en = 4'b1010;
    dp       = 4'b0000;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dis_frame got=timeout exp=pulse"); end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      checks++; if ((an[0] & an[2]) !== 1'b1) begin
        errors++; $display("FAIL dis_disabled_lit k=%0d got=%h exp=an[0],an[2] high", k, an);
      end
      checks++; if ($countones(~an) > 1) begin
        errors++; $display("FAIL dis_two_anodes k=%0d got=%h exp=at most one low", k, an);
      end
      if (k == 11 || k == 43) begin
        checks++; if (an !== 4'hD || ca !== 8'hF9) begin
          errors++; $display("FAIL dis_digit1 k=%0d got an=%h ca=%h exp an=d ca=f9", k, an, ca);
        end
      end
      if (k == 27 || k == 59) begin
        checks++; if (an !== 4'h7 || ca !== 8'hF9) begin
          errors++; $display("FAIL dis_digit3 k=%0d got an=%h ca=%h exp an=7 ca=f9", k, an, ca);
        end
      end
      if (an === 4'hF) begin
        dark++;
      end else begin
        if (prev_lit !== 4'hF && an !== prev_lit) begin
          checks++; if (dark < int'(BC)) begin
            errors++; $display("FAIL dis_gap k=%0d got=%0d exp>=%0d", k, dark, BC);
          end
        end
        prev_lit = an;
        dark = 0;
      end
    end
  endtask

  task automatic test_lzb();
    bit ok;
`ifdef SEVEN_SEGMENT_LZB_EN
    logic [3:0] ean_a[4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [3:0] ean_b[4] = '{4'hE, 4'hF, 4'hF, 4'hF};
`else
    logic [3:0] ean_a[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] ean_b[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
    logic [7:0] eca_a[4] = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
    digit_en = 4'hF;
    dp       = 4'h0;
    data     = 16'h0050;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lzb_frame_a got=timeout exp=pulse"); end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (k % 8 == 3) begin
        checks++; if (an !== ean_a[k/8]) begin
          errors++; $display("FAIL lzb_0050_an k=%0d got=%h exp=%h", k, an, ean_a[k/8]);
        end
        if (ean_a[k/8] !== 4'hF) begin
          checks++; if (ca !== eca_a[k/8]) begin
            errors++; $display("FAIL lzb_0050_ca k=%0d got=%h exp=%h", k, ca, eca_a[k/8]);
          end
        end
      end
    end
    data = 16'h0000;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lzb_frame_b got=timeout exp=pulse"); end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (k % 8 == 3) begin
        checks++; if (an !== ean_b[k/8]) begin
          errors++; $display("FAIL lzb_0000_an k=%0d got=%h exp=%h", k, an, ean_b[k/8]);
        end
        if (ean_b[k/8] !== 4'hF) begin
          checks++; if (ca !== 8'hC0) begin
            errors++; $display("FAIL lzb_0000_ca k=%0d got=%h exp=c0", k, ca);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_reset_mid_show();
    test_snapshot();
    test_disable_blanking();
    test_lzb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
